fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode/immediate generation; owns the PC and fetches one 32-bit word at a time from instruction memory over a request/response interface.
- Presents the fetched word (instr_o), its PC and PC+4 to decode through a valid/ready handshake.
- Consumes the sign-extended immediate from decode/execute to compute branch/JAL redirect targets; JALR targets come from the ALU result.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction, immediate and ALU result.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- imem_req_o  out  1  one-cycle request pulse; memory accepts it in that cycle.
- imem_addr_o  out  DATA_WIDTH  fetch address; valid while imem_req_o=1.
- imem_rvalid_i  in  1  response valid, 1+ cycles after request; one response per request.
- imem_rdata_i  in  DATA_WIDTH  instruction word when imem_rvalid_i=1.
- instr_valid_o  out  1  instr_o/pc_o/pc_plus4_o hold a live instruction.
- decode_ready_i  in  1  decode consumes the instruction when valid and ready are both 1.
- instr_o  out  DATA_WIDTH  fetched instruction.
- pc_o  out  DATA_WIDTH  PC of instr_o.
- pc_plus4_o  out  DATA_WIDTH  pc_o+4, used for JAL/JALR link.
- redirect_i  in  1  control-flow change this cycle.
- PCSrc_i  in  2  01 = PC-relative (branch/JAL), 10 = JALR; 00/11 ignored (no redirect).
- redirect_pc_i  in  DATA_WIDTH  PC of the redirecting instruction.
- ImmOp_i  in  DATA_WIDTH  sign-extended immediate (B or J format).
- ALUResult_i  in  DATA_WIDTH  rs1+imm for JALR.

Behaviour:
- Reset (async assert, sync release):
  - Internal fetch PC = RESET_PC; state = FETCH; output buffer empty.
  - instr_valid_o=0, imem_req_o=0, instr_o=0, pc_o=0, pc_plus4_o=0.
- Redirect target:
  - PCSrc_i=01: redirect_pc_i + ImmOp_i (mod 2^DATA_WIDTH).
  - PCSrc_i=10: ALUResult_i with bit0 cleared.
  - redirect_i with PCSrc_i 00/11 is a no-op.
- States:
  - FETCH: imem_req_o=1, imem_addr_o=fetch PC, then go to WAIT. If the buffer is full and not draining this cycle, no request; go to HOLD.
  - WAIT: on imem_rvalid_i, load the buffer (instr, PC, PC+4), set fetch PC += 4, go to FETCH. Next request issues the following cycle (back-to-back throughput: one instruction per 2 cycles minimum).
  - HOLD: buffer full, decode stalled. When decode_ready_i=1, the buffer drains; go to FETCH in the same edge.
  - DRAIN: a response is outstanding but killed. On imem_rvalid_i, discard it; go to FETCH with the redirect PC.
- Output timing: response in cycle N gives instr_valid_o=1 in N+1, registered. Buffer contents are held stable while valid and not ready.
- Redirect priority: redirect overrides all other events.
  - Buffer cleared next edge (instr_valid_o=0).
  - Fetch PC = target.
  - From FETCH/HOLD: go to FETCH, request target next cycle. Any request issued in the redirect cycle is killed (go to DRAIN).
  - From WAIT: go to DRAIN. If imem_rvalid_i arrives in the same cycle, discard it and go to FETCH.
  - From DRAIN: update target, stay in DRAIN.
- Fetch PC wrap-around: 32'hFFFF_FFFC + 4 = 0; no fault.
- Reset mid-transaction: state cleared immediately. A late imem_rvalid_i while in FETCH is ignored (memory is reset alongside).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: adds output misalign_o (1 bit, reset 0). A redirect with target[1:0]!=0 sets misalign_o=1 next cycle and holds it until reset. The fetch unit stays in FETCH without requesting (halt); instr_valid_o remains 0.
- Undefined: target[1:0] is forced to 00 and fetch continues.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {FETCH, WAIT, HOLD, DRAIN}.
  - typedef enum logic [1:0] pc_src_t {PC_SEQ=00, PC_REL=01, PC_JALR=10}.
  - constant INSTR_BYTES=4.
- One sub-module: fetch_buffer (single-entry valid/ready register holding instr/pc/pc_plus4, with flush input).

Test Plan:
- Reset release, 1-cycle memory latency, decode_ready_i=1 -> requests to 0x0, 0x4, 0x8 every 2 cycles; pc_o/pc_plus4_o = 0x0/0x4, 0x4/0x8 in order.
- decode_ready_i=0 after first instruction (0x00500093 at PC 0) -> instr_valid_o held, outputs stable, no new request. Release ready -> next request to 0x4 in the same cycle as the drain edge.
- Branch: redirect_i=1, PCSrc_i=01, redirect_pc_i=0x10, ImmOp_i=0xFFFFFFF8 while a request is outstanding -> the outstanding response is discarded; next request to 0x8; no instruction from the killed fetch reaches decode.
- JALR: PCSrc_i=10, ALUResult_i=0x101 -> request to 0x100. With FETCH_MISALIGN_TRAP_EN and ALUResult_i=0x102 -> misalign_o=1, no further requests.
- Redirect coinciding with imem_rvalid_i in WAIT -> data dropped, instr_valid_o=0, next cycle requests the target.
- rst_n_i asserted while WAIT -> outputs 0 asynchronously; after release first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, redirect source
// encodings and the fixed instruction size.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_REL  = 2'b01,
        PC_JALR = 2'b10
    } pc_src_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, decode valid/ready handshake and
// redirect inputs. master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if #(parameter int DATA_WIDTH = 32);

    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic                  instr_valid_o;
    logic                  decode_ready_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] pc_plus4_o;
    logic                  redirect_i;
    logic [1:0]            PCSrc_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic [DATA_WIDTH-1:0] ImmOp_i;
    logic [DATA_WIDTH-1:0] ALUResult_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
        input  imem_rvalid_i, imem_rdata_i, decode_ready_i,
        input  redirect_i, PCSrc_i, redirect_pc_i, ImmOp_i, ALUResult_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
        output imem_rvalid_i, imem_rdata_i, decode_ready_i,
        output redirect_i, PCSrc_i, redirect_pc_i, ImmOp_i, ALUResult_i
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Single-entry output register toward decode (instr, pc, pc+4): loads one cycle after
// the memory response, holds contents while valid && !ready, flush wins over load.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_instr_i,
    input  logic [DATA_WIDTH-1:0] load_pc_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = load_instr_i;
            pc_d       = load_pc_i;
            pc_plus4_d = load_pc_i + DATA_WIDTH'(INSTR_BYTES);
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one word per request, response -> decode-valid next cycle, stalls while decode
// backpressures. `define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirects (misalign_o).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    fetch_unit_if.master  bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          misalign_o
`endif
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] target_raw, target;
    logic                  redir_vld, req, load, flush, halted, buf_vld;

    assign redir_vld = bus.redirect_i && (bus.PCSrc_i == PC_REL || bus.PCSrc_i == PC_JALR);

    always_comb begin
        target_raw = bus.ALUResult_i & ~DATA_WIDTH'(1);
        if (bus.PCSrc_i == PC_REL) begin
            target_raw = bus.redirect_pc_i + bus.ImmOp_i;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign halted     = misalign_q;
    assign target     = target_raw;
    assign misalign_o = misalign_q;
`else
    assign halted = 1'b0;
    assign target = target_raw & ~DATA_WIDTH'(3);
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req        = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (halted) begin
            state_d = FETCH;
            flush   = 1'b1;
        end else if (redir_vld) begin
            // A request never issues in a redirect cycle, so only WAIT/DRAIN leave one in flight.
            flush      = 1'b1;
            fetch_pc_d = target;
            state_d    = ((state_q == WAIT || state_q == DRAIN) && !bus.imem_rvalid_i) ? DRAIN : FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = FETCH;
            end
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (buf_vld && !bus.decode_ready_i) begin
                        state_d = HOLD;
                    end else begin
                        req     = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        load       = 1'b1;
                        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(INSTR_BYTES);
                        state_d    = FETCH;
                    end
                end
                HOLD: begin
                    if (bus.decode_ready_i) state_d = FETCH;
                end
                DRAIN: begin
                    if (bus.imem_rvalid_i) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Reset state is FETCH, so the request strobe is gated to stay low while reset is held.
    assign bus.imem_req_o  = req && rst_n_i;
    assign bus.imem_addr_o = fetch_pc_q;

    fetch_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush),
        .load_i       (load),
        .load_instr_i (bus.imem_rdata_i),
        .load_pc_i    (fetch_pc_q),
        .ready_i      (bus.decode_ready_i),
        .valid_o      (buf_vld),
        .instr_o      (bus.instr_o),
        .pc_o         (bus.pc_o),
        .pc_plus4_o   (bus.pc_plus4_o)
    );

    assign bus.instr_valid_o = buf_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory, request and decode scoreboards.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {logic [31:0] addr; int due;} mem_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ins_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    fetch_unit_if #(.DATA_WIDTH(32)) bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_o;
`endif

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign_o)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    mem_t        mem_q[$];
    int          req_cyc_q[$];
    logic [31:0] exp_req_q[$];
    ins_t        exp_ins_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h0050_0093;
    endfunction

    task automatic idle_inputs();
        bus.redirect_i     = 1'b0;
        bus.PCSrc_i        = PC_SEQ;
        bus.redirect_pc_i  = '0;
        bus.ImmOp_i        = '0;
        bus.ALUResult_i    = '0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = '0;
        bus.decode_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        mem_q.delete(); req_cyc_q.delete(); exp_req_q.delete(); exp_ins_q.delete();
        mem_lat = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        cyc = 0;
    endtask

    // One clock: monitor requests/decode handshakes mid-cycle, then drive the memory response.
    task automatic step();
        logic [31:0] ea;
        ins_t        ei;
        @(negedge clk_i);
        if (bus.imem_req_o === 1'b1) begin
            req_cyc_q.push_back(cyc);
            mem_q.push_back('{addr: bus.imem_addr_o, due: cyc + mem_lat});
            n_cmp++;
            if (exp_req_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: cycle %0d addr=%h, none required", cyc, bus.imem_addr_o);
            end else begin
                ea = exp_req_q.pop_front();
                if (bus.imem_addr_o !== ea) begin
                    n_err++;
                    $display("FAIL req_addr: cycle %0d got %h required %h", cyc, bus.imem_addr_o, ea);
                end
            end
        end
        if (bus.instr_valid_o === 1'b1 && bus.decode_ready_i === 1'b1) begin
            n_cmp++;
            if (exp_ins_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_instr: cycle %0d pc=%h instr=%h, none required", cyc, bus.pc_o, bus.instr_o);
            end else begin
                ei = exp_ins_q.pop_front();
                if (bus.instr_o !== ei.instr) begin
                    n_err++;
                    $display("FAIL instr: cycle %0d got %h required %h", cyc, bus.instr_o, ei.instr);
                end
                n_cmp++;
                if (bus.pc_o !== ei.pc) begin
                    n_err++;
                    $display("FAIL pc: cycle %0d got %h required %h", cyc, bus.pc_o, ei.pc);
                end
                n_cmp++;
                if (bus.pc_plus4_o !== ei.pc + 32'd4) begin
                    n_err++;
                    $display("FAIL pc_plus4: cycle %0d got %h required %h", cyc, bus.pc_plus4_o, ei.pc + 32'd4);
                end
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        @(posedge clk_i);
        #1;
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", bus.instr_valid_o); end
        n_cmp++; if (bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b required 0", bus.imem_req_o); end
        n_cmp++; if (bus.instr_o !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h required 0", bus.instr_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h required 0", bus.pc_o); end
        n_cmp++; if (bus.pc_plus4_o !== 32'h0) begin n_err++; $display("FAIL rst_pc_plus4: got %h required 0", bus.pc_plus4_o); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b required 0", misalign_o); end
`endif
    endtask

    task automatic test_sequential();
        do_reset();
        exp_req_q = '{32'h0, 32'h4, 32'h8};
        exp_ins_q.push_back('{pc: 32'h0, instr: mem_word(32'h0)});
        exp_ins_q.push_back('{pc: 32'h4, instr: mem_word(32'h4)});
        repeat (5) step();
        n_cmp++; if (exp_req_q.size() != 0 || exp_ins_q.size() != 0) begin n_err++;
            $display("FAIL seq_pending: got %0d reqs/%0d instrs left, required 0/0", exp_req_q.size(), exp_ins_q.size()); end
        n_cmp++; if (req_cyc_q.size() != 3 || req_cyc_q[1] - req_cyc_q[0] != 2 || req_cyc_q[2] - req_cyc_q[1] != 2) begin n_err++;
            $display("FAIL seq_spacing: got %0d requests, required 3 spaced by 2 cycles", req_cyc_q.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.decode_ready_i = 1'b0;
        exp_req_q.push_back(32'h0);
        repeat (2) step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h0050_0093) begin n_err++;
            $display("FAIL stall_load: got valid=%b instr=%h required 1/00500093", bus.instr_valid_o, bus.instr_o); end
        repeat (3) step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h0050_0093 || bus.pc_o !== 32'h0 || bus.pc_plus4_o !== 32'h4) begin
            n_err++; $display("FAIL stall_hold: got valid=%b instr=%h pc=%h pc4=%h required 1/00500093/0/4",
                              bus.instr_valid_o, bus.instr_o, bus.pc_o, bus.pc_plus4_o); end
        exp_ins_q.push_back('{pc: 32'h0, instr: mem_word(32'h0)});
        exp_req_q.push_back(32'h4);
        bus.decode_ready_i = 1'b1;
        step();
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_drain: got valid=%b required 0", bus.instr_valid_o); end
        step();
        n_cmp++; if (exp_req_q.size() != 0 || req_cyc_q.size() != 2 || req_cyc_q[1] != 6) begin n_err++;
            $display("FAIL stall_resume: got %0d requests (%0d pending), required second request in cycle 6", req_cyc_q.size(), exp_req_q.size()); end
    endtask

    task automatic test_branch();
        do_reset();
        mem_lat = 3;
        exp_req_q = '{32'h0, 32'h8};
        exp_ins_q.push_back('{pc: 32'h8, instr: mem_word(32'h8)});
        step();
        bus.redirect_i = 1'b1; bus.PCSrc_i = PC_REL; bus.redirect_pc_i = 32'h10; bus.ImmOp_i = 32'hFFFF_FFF8;
        step();
        idle_inputs();
        repeat (6) step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.instr_o !== mem_word(32'h8)) begin n_err++;
            $display("FAIL branch_target_instr: got valid=%b pc=%h instr=%h required 1/8/%h", bus.instr_valid_o, bus.pc_o, bus.instr_o, mem_word(32'h8)); end
        n_cmp++; if (exp_req_q.size() != 0 || req_cyc_q.size() != 2 || req_cyc_q[1] != 4) begin n_err++;
            $display("FAIL branch_refetch: got %0d requests (%0d pending), required refetch in cycle 4", req_cyc_q.size(), exp_req_q.size()); end
    endtask

    task automatic test_jalr();
        do_reset();
        bus.redirect_i = 1'b1; bus.PCSrc_i = PC_JALR; bus.ALUResult_i = 32'h101;
        step();
        idle_inputs();
        exp_req_q.push_back(32'h100);
        step();
        n_cmp++; if (exp_req_q.size() != 0 || req_cyc_q.size() != 1 || req_cyc_q[0] != 1) begin n_err++;
            $display("FAIL jalr_req: got %0d requests (%0d pending), required one request in cycle 1", req_cyc_q.size(), exp_req_q.size()); end
    endtask

    task automatic test_misalign();
        do_reset();
        bus.redirect_i = 1'b1; bus.PCSrc_i = PC_JALR; bus.ALUResult_i = 32'h102;
        step();
        idle_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL misalign_set: got %b required 1", misalign_o); end
        repeat (4) step();
        n_cmp++; if (misalign_o !== 1'b1 || bus.instr_valid_o !== 1'b0 || req_cyc_q.size() != 0) begin n_err++;
            $display("FAIL misalign_halt: got misalign=%b valid=%b reqs=%0d required 1/0/0", misalign_o, bus.instr_valid_o, req_cyc_q.size()); end
`else
        exp_req_q.push_back(32'h100);
        step();
        n_cmp++; if (exp_req_q.size() != 0 || req_cyc_q.size() != 1) begin n_err++;
            $display("FAIL misalign_forced: got %0d requests (%0d pending), required one to 00000100", req_cyc_q.size(), exp_req_q.size()); end
`endif
    endtask

    task automatic test_coincide();
        do_reset();
        exp_req_q.push_back(32'h0);
        step();
        bus.redirect_i = 1'b1; bus.PCSrc_i = PC_REL; bus.redirect_pc_i = 32'h40; bus.ImmOp_i = 32'h20;
        exp_req_q.push_back(32'h60);
        step();
        idle_inputs();
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL coincide_drop: got valid=%b required 0", bus.instr_valid_o); end
        step();
        n_cmp++; if (exp_req_q.size() != 0 || req_cyc_q.size() != 2 || req_cyc_q[1] != 2) begin n_err++;
            $display("FAIL coincide_refetch: got %0d requests (%0d pending), required target request in cycle 2", req_cyc_q.size(), exp_req_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_req_q = '{32'h0, 32'h4};
        exp_ins_q.push_back('{pc: 32'h0, instr: mem_word(32'h0)});
        repeat (3) step();
        #2 rst_n_i = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.pc_plus4_o !== 32'h0) begin
            n_err++; $display("FAIL async_reset: got valid=%b req=%b instr=%h pc4=%h required all 0",
                              bus.instr_valid_o, bus.imem_req_o, bus.instr_o, bus.pc_plus4_o); end
        bus.imem_rvalid_i = 1'b0;
        mem_q.delete(); req_cyc_q.delete(); exp_req_q.delete(); exp_ins_q.delete();
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        cyc = 0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        exp_req_q.push_back(32'h0);
        repeat (2) step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== mem_word(32'h0) || exp_req_q.size() != 0) begin
            n_err++; $display("FAIL reset_refetch: got valid=%b pc=%h instr=%h required 1/0/%h",
                              bus.instr_valid_o, bus.pc_o, bus.instr_o, mem_word(32'h0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.redirect_i = 1'b1; bus.PCSrc_i = PC_JALR; bus.ALUResult_i = 32'hFFFF_FFFC;
        exp_req_q = '{32'hFFFF_FFFC, 32'h0};
        exp_ins_q.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
        step();
        idle_inputs();
        repeat (3) step();
        n_cmp++; if (exp_req_q.size() != 0 || exp_ins_q.size() != 0) begin n_err++;
            $display("FAIL wrap_pending: got %0d reqs/%0d instrs left, required 0/0", exp_req_q.size(), exp_ins_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jalr();
        test_misalign();
        test_coincide();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
